// File: rtl/id_ex_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_if
//  Purpose  : ID->EX bundle handshake, flush and status signals.
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_pipe_if #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  inst_i;
    logic [XLEN-1:0]  inst_addr_i;
    logic [XLEN-1:0]  op_num1_i;
    logic [XLEN-1:0]  op_num2_i;
    logic [RD_W-1:0]  rd_addr_i;
    logic             reg_wen_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  inst_o;
    logic [XLEN-1:0]  inst_addr_o;
    logic [XLEN-1:0]  op_num1_o;
    logic [XLEN-1:0]  op_num2_o;
    logic [RD_W-1:0]  rd_addr_o;
    logic             reg_wen_o;
    logic             flush_i;
    logic [1:0]       occ_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Driven by the ID side / environment.
    modport master (
        output in_valid_i, inst_i, inst_addr_i, op_num1_i, op_num2_i,
               rd_addr_i, reg_wen_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, inst_o, inst_addr_o, op_num1_o,
               op_num2_o, rd_addr_o, reg_wen_o, occ_o, stall_cnt_o
    );

    // Seen by the pipeline register itself.
    modport slave (
        input  in_valid_i, inst_i, inst_addr_i, op_num1_i, op_num2_i,
               rd_addr_i, reg_wen_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, inst_o, inst_addr_o, op_num1_o,
               op_num2_o, rd_addr_o, reg_wen_o, occ_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe
//  Purpose  : ID/EX pipeline register with skid entry, flush and stall count.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe #(
    parameter int              XLEN     = 32,
    parameter int              RD_W     = 5,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013,
    parameter int              CNT_W    = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    id_ex_pipe_if.slave      bus
);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] inst_addr;
        logic [XLEN-1:0] op_num1;
        logic [XLEN-1:0] op_num2;
        logic [RD_W-1:0] rd_addr;
        logic            reg_wen;
    } bundle_t;

    bundle_t          r_main;
    bundle_t          r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    bundle_t          w_in_bundle;
    logic             w_accept;
    logic             w_drain;
    logic             w_stall;

    assign w_in_bundle = '{inst:      bus.inst_i,
                           inst_addr: bus.inst_addr_i,
                           op_num1:   bus.op_num1_i,
                           op_num2:   bus.op_num2_i,
                           rd_addr:   bus.rd_addr_i,
                           reg_wen:   bus.reg_wen_i};

    // Ready comes only from the skid flag so the ID side never sees EX ready combinationally.
    assign w_accept = bus.in_valid_i & ~r_skid_valid;
    assign w_drain  = r_main_valid & bus.out_ready_i;
    assign w_stall  = r_main_valid & ~bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (bus.flush_i) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_main_valid || w_drain) begin
                // Skid is older than anything arriving now, so it moves up first.
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main       <= w_in_bundle;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_in_bundle;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o  = ~r_skid_valid;
    assign bus.out_valid_o = r_main_valid;
    assign bus.inst_o      = r_main_valid ? r_main.inst      : NOP_INST;
    assign bus.inst_addr_o = r_main_valid ? r_main.inst_addr : '0;
    assign bus.op_num1_o   = r_main_valid ? r_main.op_num1   : '0;
    assign bus.op_num2_o   = r_main_valid ? r_main.op_num2   : '0;
    assign bus.rd_addr_o   = r_main_valid ? r_main.rd_addr   : '0;
    assign bus.reg_wen_o   = r_main_valid & r_main.reg_wen;
    assign bus.occ_o       = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe
//  Purpose  : Self-checking bench for id_ex_pipe (vectors, directed, random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe;

    localparam logic [31:0] c_NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } bnd_t;

    typedef struct {
        bit          r, fl, iv, ordy;
        logic [31:0] inst;
        bit          e_ov;
        logic [31:0] e_inst;
        bit          e_rdy;
        int          e_occ;
        int          e_stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    id_ex_pipe_if #(.XLEN(32), .RD_W(5), .CNT_W(16)) bus ();
    id_ex_pipe_if #(.XLEN(32), .RD_W(5), .CNT_W(4))  bus2 ();

    id_ex_pipe #(.XLEN(32), .RD_W(5), .NOP_INST(c_NOP), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_ex_pipe #(.XLEN(32), .RD_W(5), .NOP_INST(c_NOP), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    function automatic bnd_t mk_bnd(logic [31:0] inst);
        bnd_t b;
        b.inst = inst;
        b.addr = {inst[29:0], 2'b00};
        b.op1  = ~inst;
        b.op2  = inst ^ 32'h5a5a_5a5a;
        b.rd   = inst[6:2];
        b.wen  = inst[0] ^ inst[7];
        return b;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_all(string tag, bit e_ov, bnd_t e_b, bit e_rdy,
                                      int e_occ, int e_stall);
        bnd_t eb;
        if (e_ov) begin
            eb = e_b;
        end else begin
            eb      = '0;
            eb.inst = c_NOP;
        end
        chk({tag, ".out_valid"}, 64'(bus.out_valid_o), 64'(e_ov));
        chk({tag, ".inst"},      64'(bus.inst_o),      64'(eb.inst));
        chk({tag, ".inst_addr"}, 64'(bus.inst_addr_o), 64'(eb.addr));
        chk({tag, ".op1"},       64'(bus.op_num1_o),   64'(eb.op1));
        chk({tag, ".op2"},       64'(bus.op_num2_o),   64'(eb.op2));
        chk({tag, ".rd"},        64'(bus.rd_addr_o),   64'(eb.rd));
        chk({tag, ".wen"},       64'(bus.reg_wen_o),   64'(eb.wen));
        chk({tag, ".in_ready"},  64'(bus.in_ready_o),  64'(e_rdy));
        chk({tag, ".occ"},       64'(bus.occ_o),       64'(e_occ));
        chk({tag, ".stall"},     64'(bus.stall_cnt_o), 64'(e_stall));
    endfunction

    task automatic drive(bit r, bit fl, bit iv, bit ordy, bnd_t b);
        rst             = r;
        bus.flush_i     = fl;
        bus.in_valid_i  = iv;
        bus.out_ready_i = ordy;
        bus.inst_i      = b.inst;
        bus.inst_addr_i = b.addr;
        bus.op_num1_i   = b.op1;
        bus.op_num2_i   = b.op2;
        bus.rd_addr_i   = b.rd;
        bus.reg_wen_i   = b.wen;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Queue model: the stage is a two-deep FIFO, ready while fewer than two are held.
    bnd_t q[$];
    int   m_stall;

    task automatic model_cycle(bit r, bit fl, bit iv, bit ordy, bnd_t b);
        bit acc, drn, stl;
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        stl = (q.size() > 0) && !ordy;
        drive(r, fl, iv, ordy, b);
        tick();
        if (r) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (stl && m_stall < 65535) m_stall++;
            if (fl) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
        check_all("rand", q.size() > 0, (q.size() > 0) ? q[0] : bnd_t'('0),
                  q.size() < 2, q.size(), m_stall);
    endtask

    vec_t tbl[8];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk_bnd(32'h0));
        bus2.flush_i = 1'b0; bus2.in_valid_i = 1'b0; bus2.out_ready_i = 1'b0;
        bus2.inst_i = 32'h55; bus2.inst_addr_i = '0; bus2.op_num1_i = '0;
        bus2.op_num2_i = '0; bus2.rd_addr_i = '0; bus2.reg_wen_i = 1'b0;

        // Reset, idle, then backpressure with A,B,C.
        tbl[0] = '{1, 0, 0, 0, 32'h0,  0, c_NOP, 1, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 32'h0,  0, c_NOP, 1, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 32'hA,  1, 32'hA, 1, 1, 0};
        tbl[3] = '{0, 0, 1, 0, 32'hB,  1, 32'hA, 0, 2, 1};
        tbl[4] = '{0, 0, 1, 0, 32'hC,  1, 32'hA, 0, 2, 2};
        tbl[5] = '{0, 0, 1, 1, 32'hC,  1, 32'hB, 1, 1, 2};
        tbl[6] = '{0, 0, 1, 1, 32'hC,  1, 32'hC, 1, 1, 2};
        tbl[7] = '{0, 0, 0, 1, 32'h0,  0, c_NOP, 1, 0, 2};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].ordy, mk_bnd(tbl[i].inst));
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].e_ov, mk_bnd(tbl[i].e_inst),
                      tbl[i].e_rdy, tbl[i].e_occ, tbl[i].e_stall);
        end

        // Streaming 0x100..0x107 at full rate.
        drive(1, 0, 0, 0, mk_bnd(0)); tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, mk_bnd(32'h100 + i));
            tick();
            check_all($sformatf("stream%0d", i), 1, mk_bnd(32'h100 + i), 1, 1, 0);
        end
        drive(0, 0, 0, 1, mk_bnd(0)); tick();
        check_all("stream_end", 0, '0, 1, 0, 0);

        // Flush with skid full, then flush with accept into a full main.
        drive(1, 0, 0, 0, mk_bnd(0)); tick();
        drive(0, 0, 1, 0, mk_bnd(32'h2A)); tick();
        drive(0, 0, 1, 0, mk_bnd(32'h2B)); tick();
        check_all("fl_full", 1, mk_bnd(32'h2A), 0, 2, 1);
        drive(0, 1, 1, 0, mk_bnd(32'h2C)); tick();
        check_all("fl_empty", 0, '0, 1, 0, 2);
        drive(0, 0, 1, 1, mk_bnd(32'h2D)); tick();
        check_all("fl_after", 1, mk_bnd(32'h2D), 1, 1, 2);
        drive(0, 1, 1, 0, mk_bnd(32'h2E)); tick();
        check_all("fl_acc", 0, '0, 1, 0, 3);
        drive(0, 0, 1, 1, mk_bnd(32'h2F)); tick();
        check_all("fl_next", 1, mk_bnd(32'h2F), 1, 1, 3);

        // Reset in the middle of backpressure.
        drive(1, 0, 0, 0, mk_bnd(0)); tick();
        drive(0, 0, 1, 0, mk_bnd(32'h3A)); tick();
        drive(0, 0, 1, 0, mk_bnd(32'h3B)); tick();
        drive(0, 0, 0, 0, mk_bnd(0));
        repeat (4) tick();
        check_all("rstbp_pre", 1, mk_bnd(32'h3A), 0, 2, 5);
        drive(1, 1, 1, 1, mk_bnd(32'h3C)); tick();
        check_all("rstbp_post", 0, '0, 1, 0, 0);

        // Saturation on the narrow-counter instance.
        rst2 = 1'b1; tick();
        rst2 = 1'b0; bus2.in_valid_i = 1'b1; tick();
        bus2.in_valid_i = 1'b0;
        repeat (14) tick();
        chk("sat14", 64'(bus2.stall_cnt_o), 64'd14);
        repeat (6) tick();
        chk("sat20", 64'(bus2.stall_cnt_o), 64'd15);
        chk("sat_occ", 64'(bus2.occ_o), 64'd1);

        // Randomized traffic against the queue model.
        model_cycle(1, 0, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            bnd_t b;
            b.inst = $urandom; b.addr = $urandom; b.op1 = $urandom; b.op2 = $urandom;
            b.rd = 5'($urandom); b.wen = 1'($urandom);
            model_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                        $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
